mem_stage: RTL

//  MEM stage of the 5-stage SimpleCPU pipeline: registers ex_to_mem_bus, runs load/store on the sram-like

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/mem_stage_load_align.sv | 39 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall polarity, load-op bit positions, FSM states and the
// EX->MEM bus layout for the MEM pipeline stage.
package mem_stage_pkg;

   localparam int unsigned EX_TO_MEM_WD = 178;
   localparam int unsigned MEM_TO_WB_WD = 136;
   localparam int unsigned MEM_TO_RF_WD = 38;
   localparam int unsigned STALL_WD     = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam int unsigned LD_LB  = 4;
   localparam int unsigned LD_LBU = 3;
   localparam int unsigned LD_LH  = 2;
   localparam int unsigned LD_LHU = 1;
   localparam int unsigned LD_LW  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic        mem_en;
      logic [3:0]  mem_wen;
      logic [4:0]  load_op;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
      logic [31:0] store_data;
      logic        hi_we;
      logic        lo_we;
      logic [31:0] hi;
      logic [31:0] lo;
   } ex_mem_t;

   // Access size from the load kind or the store strobe pattern: 0=byte, 1=half, 2=word.
   function automatic logic [1:0] access_size(input logic [4:0] load_op, input logic [3:0] wen);
      logic [1:0] size;
      size = 2'd0;
      if (load_op[LD_LH] || load_op[LD_LHU] || wen == 4'b0011 || wen == 4'b1100)
         size = 2'd1;
      if (load_op[LD_LW] || wen == 4'b1111)
         size = 2'd2;
      return size;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment: picks the byte/half lane selected by the
// low address bits and sign- or zero-extends it.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [4:0]  load_op,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[7:0];
      case (addr)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      if (load_op[LD_LB])
         result = {{24{byte_lane[7]}}, byte_lane};
      else if (load_op[LD_LBU])
         result = {24'd0, byte_lane};
      else if (load_op[LD_LH])
         result = {{16{half_lane[15]}}, half_lane};
      else if (load_op[LD_LHU])
         result = {16'd0, half_lane};
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, runs load/store on the
// sram-like data port and feeds the WB stage and ID forwarding.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned STALL_IDX = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic                    data_sram_req,
   output logic                    data_sram_wr,
   output logic [1:0]              data_sram_size,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   input  logic                    data_sram_addr_ok,
   input  logic                    data_sram_data_ok,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
   output logic                    stallreq_for_mem
);

   ex_mem_t    ex_in;
   ex_mem_t    bus_r;
   mem_state_e state;
   mem_state_e state_nxt;
   logic [31:0] rdata_r;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        capture;
   logic        bubble;
   logic        wr;
   logic        is_load;
   logic        rdata_we;

   assign ex_in   = ex_to_mem_bus;
   assign capture = (stall[STALL_IDX] == NO_STOP);
   assign bubble  = (stall[STALL_IDX] == STOP) && (stall[STALL_IDX+1] == NO_STOP);
   assign wr      = bus_r.mem_en & (|bus_r.mem_wen);
   assign is_load = |bus_r.load_op;

   always_ff @(posedge clk) begin
      if (rst)
         bus_r <= '0;
      else if (bubble)
         bus_r <= '0;
      else if (capture)
         bus_r <= ex_in;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rdata_r <= '0;
      else if (rdata_we)
         rdata_r <= data_sram_rdata;
   end

   // A capture (or bubble) restarts the FSM from the incoming op regardless of current state.
   always_comb begin
      state_nxt = state;
      if (capture)
         state_nxt = ex_in.mem_en ? ST_REQ : ST_IDLE;
      else if (bubble)
         state_nxt = ST_IDLE;
      else begin
         case (state)
            ST_REQ: begin
               if (data_sram_addr_ok && wr)
                  state_nxt = ST_DONE;
               else if (data_sram_addr_ok && data_sram_data_ok)
                  state_nxt = ST_DONE;
               else if (data_sram_addr_ok)
                  state_nxt = ST_WAIT;
            end
            ST_WAIT: if (data_sram_data_ok) state_nxt = ST_DONE;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      data_sram_req    = (state == ST_REQ);
      stallreq_for_mem = (state == ST_REQ) || (state == ST_WAIT);
      rdata_we         = 1'b0;
      if (!capture && !bubble) begin
         if (state == ST_REQ)
            rdata_we = data_sram_addr_ok && !wr && data_sram_data_ok;
         else if (state == ST_WAIT)
            rdata_we = data_sram_data_ok;
      end
   end

   assign data_sram_wr    = wr;
   assign data_sram_wen   = bus_r.mem_en ? bus_r.mem_wen : 4'h0;
   assign data_sram_size  = access_size(bus_r.load_op, bus_r.mem_wen);
   assign data_sram_addr  = bus_r.ex_result;
   assign data_sram_wdata = bus_r.store_data;

   mem_stage_load_align u_load_align (
      .rdata   (rdata_r),
      .addr    (bus_r.ex_result[1:0]),
      .load_op (bus_r.load_op),
      .result  (load_data)
   );

   assign rf_wdata = is_load ? load_data : bus_r.ex_result;

   assign mem_to_wb_bus = {bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, rf_wdata,
                           bus_r.hi_we, bus_r.lo_we, bus_r.hi, bus_r.lo};

   assign mem_to_rf_bus = {bus_r.rf_we & ~(is_load & (state != ST_DONE)),
                           bus_r.rf_waddr, rf_wdata};

endmodule
